// File: rtl/act_mem_ext_write_port_pkg.sv
// Shared activation-memory parameters, loader FSM states and the byte-address to
// bank/row mapping used by both the external write port and the activation read path.
package act_mem_ext_write_port_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned ADDR_W     = 14;
    localparam int unsigned ROW_ADDR_W = 11;
    localparam int unsigned N_BANKS    = 2;
    localparam int unsigned BUF_BYTES  = 8192;

    localparam int unsigned BANK_W   = (N_BANKS > 1) ? $clog2(N_BANKS) : 1;
    localparam int unsigned BUF_ROWS = BUF_BYTES / 4;

    typedef enum logic [1:0] {WP_IDLE, WP_RUN, WP_DONE} wp_state_t;

    typedef struct packed {
        logic [BANK_W-1:0]     bank;
        logic [ROW_ADDR_W-1:0] row;
    } act_row_t;

    // One 32-bit word per SRAM row; macros are stacked in depth above ROW_ADDR_W.
    function automatic act_row_t act_row_map(input logic [ADDR_W-1:0] abs_addr);
        logic [ADDR_W-3:0] word;
        act_row_t          m;
        word   = abs_addr[ADDR_W-1:2];
        m.bank = word[ROW_ADDR_W +: BANK_W];
        m.row  = word[ROW_ADDR_W-1:0];
        return m;
    endfunction

endpackage

// File: rtl/act_mem_ext_write_port.sv
// Streams 32-bit external words into one half of the double-buffered activation SRAM,
// one row per beat, with a registered SRAM write interface (latency 1).
module act_mem_ext_write_port
    import act_mem_ext_write_port_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  cfg_start_i,
    input  logic [ADDR_W-2:0]     cfg_base_i,
    input  logic [ADDR_W-3:0]     cfg_len_i,
    input  logic                  cfg_buf_i,
    input  logic [DATA_W-1:0]     data_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic [N_BANKS-1:0]    sram_cs_o,
    output logic                  sram_we_o,
    output logic [ROW_ADDR_W-1:0] sram_addr_o,
    output logic [3:0]            sram_be_o,
    output logic [DATA_W-1:0]     sram_wdata_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);

    wp_state_t             state_q;
    logic [ADDR_W-1:0]     abs_addr_q;
    logic [ADDR_W-3:0]     remaining_q;
    logic                  ready_q, busy_q, done_q, err_q, we_q;
    logic [N_BANKS-1:0]    cs_q;
    logic [ROW_ADDR_W-1:0] addr_q;
    logic [3:0]            be_q;
    logic [DATA_W-1:0]     wdata_q;

    logic                  bad_base, overrun, accept;
    logic [ADDR_W-2:0]     end_row;
    act_row_t              map;

    // Pre-check keeps every beat inside the selected buffer half.
    always_comb begin
        bad_base = |cfg_base_i[1:0];
        end_row  = (ADDR_W-1)'(cfg_base_i >> 2) + (ADDR_W-1)'(cfg_len_i);
        overrun  = end_row > (ADDR_W-1)'(BUF_ROWS);
        accept   = valid_i && ready_q;
        map      = act_row_map(abs_addr_q);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= WP_IDLE;
            abs_addr_q  <= '0;
            remaining_q <= '0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            we_q        <= 1'b0;
            cs_q        <= '0;
            addr_q      <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
        end else begin
            cs_q   <= '0;
            we_q   <= 1'b0;
            be_q   <= '0;
            done_q <= 1'b0;
            unique case (state_q)
                WP_IDLE: begin
                    if (cfg_start_i) begin
                        abs_addr_q  <= {cfg_buf_i, cfg_base_i};
                        remaining_q <= cfg_len_i;
                        err_q       <= bad_base || overrun;
                        busy_q      <= 1'b1;
                        if (cfg_len_i == '0 || bad_base || overrun) begin
                            state_q <= WP_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= WP_RUN;
                            ready_q <= 1'b1;
                        end
                    end
                end
                WP_RUN: begin
                    if (accept) begin
                        cs_q        <= N_BANKS'(1) << map.bank;
                        we_q        <= 1'b1;
                        addr_q      <= map.row;
                        be_q        <= 4'hF;
                        wdata_q     <= data_i;
                        abs_addr_q  <= abs_addr_q + ADDR_W'(4);
                        remaining_q <= remaining_q - (ADDR_W-2)'(1);
                        if (remaining_q == (ADDR_W-2)'(1)) begin
                            state_q <= WP_DONE;
                            ready_q <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                WP_DONE: begin
                    state_q <= WP_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= WP_IDLE;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ready_o      = ready_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign sram_cs_o    = cs_q;
    assign sram_we_o    = we_q;
    assign sram_addr_o  = addr_q;
    assign sram_be_o    = be_q;
    assign sram_wdata_o = wdata_q;

endmodule
